// File: rtl/lfsr_run_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : lfsr_run_controller                                        |
// | Description : Button-driven run sequencer for the LFSR/detector datapath. |
// |               Issues clear and run-enable, counts LFSR periods, honours  |
// |               pause requests and latches the detection total.            |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module lfsr_run_controller #(
    parameter int PERIODS     = 4,
    parameter int PERIOD_W    = 3,
    parameter int HOLD_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                stop,
    input  logic                max_tick,
    input  logic                seq_det,
    input  logic                pause_req,
    output logic                run_en,
    output logic                clr,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    hits,
    output logic [PERIOD_W-1:0] period_idx
);

    localparam int HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    localparam logic [PERIOD_W-1:0] c_PERIODS   = PERIOD_W'(PERIODS);
    localparam logic [HOLD_W-1:0]   c_HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                run_en_q, run_en_d;
    logic                clr_q, clr_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    hits_q, hits_d;
    logic [CNT_W-1:0]    hit_acc_q, hit_acc_d;
    logic [PERIOD_W-1:0] period_idx_q, period_idx_d;
    logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;

    logic start_meta_q, start_sync_q, start_prev_q;
    logic stop_meta_q, stop_sync_q, stop_prev_q;

    logic                start_edge;
    logic                stop_edge;
    logic [CNT_W-1:0]    hit_inc;
    logic [PERIOD_W-1:0] period_next;

    // Chains reset high so a button held through reset never looks like a press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_meta_q <= 1'b1;
            start_sync_q <= 1'b1;
            start_prev_q <= 1'b1;
            stop_meta_q  <= 1'b1;
            stop_sync_q  <= 1'b1;
            stop_prev_q  <= 1'b1;
        end else begin
            start_meta_q <= start;
            start_sync_q <= start_meta_q;
            start_prev_q <= start_sync_q;
            stop_meta_q  <= stop;
            stop_sync_q  <= stop_meta_q;
            stop_prev_q  <= stop_sync_q;
        end
    end

    assign start_edge  = start_sync_q & ~start_prev_q;
    assign stop_edge   = stop_sync_q & ~stop_prev_q;
    assign hit_inc     = (seq_det && !(&hit_acc_q)) ? hit_acc_q + CNT_W'(1) : hit_acc_q;
    assign period_next = period_idx_q + PERIOD_W'(1);

    always_comb begin
        state_d      = state_q;
        hits_d       = hits_q;
        hit_acc_d    = hit_acc_q;
        period_idx_d = period_idx_q;
        hold_cnt_d   = hold_cnt_q;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = stop_edge ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                if (stop_edge) begin
                    state_d = ST_IDLE;
                end else if (max_tick && (period_next == c_PERIODS)) begin
                    hits_d       = hit_inc;
                    hit_acc_d    = hit_inc;
                    period_idx_d = period_next;
                    state_d      = ST_DONE;
                end else begin
                    hit_acc_d = hit_inc;
                    if (max_tick) begin
                        period_idx_d = period_next;
                    end
                    if (pause_req) begin
                        state_d = ST_PAUSE;
                    end
                end
            end
            ST_PAUSE: begin
                if (stop_edge) begin
                    state_d = ST_IDLE;
                end else if (!pause_req) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                if (stop_edge) begin
                    state_d = ST_IDLE;
                end else if (start_edge) begin
                    state_d = ST_CLEAR;
                end else if (hold_cnt_q == c_HOLD_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Clearing on entry makes period_idx read zero throughout CLEAR.
        if ((state_d == ST_CLEAR) && (state_q != ST_CLEAR)) begin
            hit_acc_d    = '0;
            period_idx_d = '0;
        end
        if ((state_d == ST_DONE) && (state_q != ST_DONE)) begin
            hold_cnt_d = '0;
        end

        run_en_d = (state_d == ST_RUN);
        clr_d    = (state_d == ST_CLEAR);
        busy_d   = (state_d == ST_CLEAR) || (state_d == ST_RUN) || (state_d == ST_PAUSE);
        done_d   = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            run_en_q     <= 1'b0;
            clr_q        <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            hits_q       <= '0;
            hit_acc_q    <= '0;
            period_idx_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            run_en_q     <= run_en_d;
            clr_q        <= clr_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            hits_q       <= hits_d;
            hit_acc_q    <= hit_acc_d;
            period_idx_q <= period_idx_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign run_en     = run_en_q;
    assign clr        = clr_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign hits       = hits_q;
    assign period_idx = period_idx_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_run_controller.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_lfsr_run_controller                                     |
// | Description : Directed self-checking bench for lfsr_run_controller.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_lfsr_run_controller;

    localparam int PERIODS     = 2;
    localparam int PERIOD_W    = 2;
    localparam int HOLD_CYCLES = 8;
    localparam int CNT_W       = 8;

    logic                clk;
    logic                reset;
    logic                start;
    logic                stop;
    logic                max_tick;
    logic                seq_det;
    logic                pause_req;
    logic                run_en;
    logic                clr;
    logic                busy;
    logic                done;
    logic [CNT_W-1:0]    hits;
    logic [PERIOD_W-1:0] period_idx;

    int vectors;
    int miscompares;

    lfsr_run_controller #(
        .PERIODS     (PERIODS),
        .PERIOD_W    (PERIOD_W),
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .max_tick   (max_tick),
        .seq_det    (seq_det),
        .pause_req  (pause_req),
        .run_en     (run_en),
        .clr        (clr),
        .busy       (busy),
        .done       (done),
        .hits       (hits),
        .period_idx (period_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance n rising edges, leaving time 1 ns past the last one.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // From IDLE: produce a clean start rise and land in RUN.
    task automatic do_start();
        start = 1'b0;
        tick(3);
        start = 1'b1;
        tick(3);
        chk("start_clr", clr, 1);
        chk("start_pidx0", period_idx, 0);
        tick(1);
        chk("start_run", run_en, 1);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b0;
        start       = 1'b1;
        stop        = 1'b0;
        max_tick    = 1'b0;
        seq_det     = 1'b0;
        pause_req   = 1'b0;

        // 1: start held through reset gives no edge
        tick(3);
        chk("rst_run_en", run_en, 0);
        chk("rst_clr", clr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hits", hits, 0);
        chk("rst_pidx", period_idx, 0);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            chk("held_clr", clr, 0);
            chk("held_busy", busy, 0);
        end
        start = 1'b0;
        tick(3);
        start = 1'b1;
        tick(1);
        chk("s1_k_clr", clr, 0);
        tick(1);
        chk("s1_k1_clr", clr, 0);
        chk("s1_k1_busy", busy, 0);
        tick(1);
        chk("s1_k2_clr", clr, 1);
        chk("s1_k2_run_en", run_en, 0);
        tick(1);
        chk("s1_k3_clr", clr, 0);
        chk("s1_k3_run_en", run_en, 1);

        // 2: three detections, two periods
        seq_det = 1'b1;
        tick(3);
        seq_det = 1'b0;
        tick(1);
        max_tick = 1'b1;
        tick(1);
        max_tick = 1'b0;
        chk("s2_pidx1", period_idx, 1);
        chk("s2_run1", run_en, 1);
        tick(2);
        max_tick = 1'b1;
        tick(1);
        max_tick = 1'b0;
        chk("s2_pidx2", period_idx, 2);
        chk("s2_run_off", run_en, 0);
        chk("s2_done", done, 1);
        chk("s2_hits", hits, 3);
        chk("s2_busy", busy, 0);
        tick(7);
        chk("s2_done_last", done, 1);
        tick(1);
        chk("s2_done_fall", done, 0);
        chk("s2_idle_hits", hits, 3);
        chk("s2_idle_busy", busy, 0);

        // 3: pause for five cycles, paused events ignored
        do_start();
        seq_det = 1'b1;
        tick(1);
        seq_det   = 1'b0;
        pause_req = 1'b1;
        tick(1);
        chk("s3_pause_n", run_en, 0);
        seq_det = 1'b1;
        tick(2);
        seq_det  = 1'b0;
        max_tick = 1'b1;
        tick(1);
        max_tick = 1'b0;
        tick(1);
        chk("s3_pause_n4", run_en, 0);
        chk("s3_pause_busy", busy, 1);
        pause_req = 1'b0;
        tick(1);
        chk("s3_resume", run_en, 1);
        chk("s3_pidx0", period_idx, 0);
        max_tick = 1'b1;
        tick(1);
        max_tick = 1'b0;
        chk("s3_pidx1", period_idx, 1);
        tick(1);
        max_tick = 1'b1;
        tick(1);
        max_tick = 1'b0;
        chk("s3_done", done, 1);
        chk("s3_hits", hits, 1);
        tick(8);
        chk("s3_idle", done, 0);

        // 4: stop mid-run leaves hits untouched
        do_start();
        seq_det = 1'b1;
        tick(2);
        seq_det = 1'b0;
        stop    = 1'b1;
        tick(2);
        chk("s4_k1_run", run_en, 1);
        tick(1);
        chk("s4_k2_busy", busy, 0);
        chk("s4_k2_run", run_en, 0);
        chk("s4_k2_done", done, 0);
        chk("s4_hits", hits, 1);
        stop = 1'b0;
        tick(3);

        // 5: accumulator saturates
        do_start();
        seq_det = 1'b1;
        tick(300);
        seq_det  = 1'b0;
        max_tick = 1'b1;
        tick(1);
        max_tick = 1'b0;
        tick(1);
        max_tick = 1'b1;
        tick(1);
        max_tick = 1'b0;
        chk("s5_done", done, 1);
        chk("s5_hits", hits, 255);
        tick(8);
        chk("s5_idle", done, 0);

        // 6: final tick beats pause, same-cycle detection counted
        do_start();
        seq_det = 1'b1;
        tick(4);
        seq_det  = 1'b0;
        max_tick = 1'b1;
        tick(1);
        chk("s6_pidx1", period_idx, 1);
        seq_det   = 1'b1;
        pause_req = 1'b1;
        tick(1);
        max_tick  = 1'b0;
        seq_det   = 1'b0;
        pause_req = 1'b0;
        chk("s6_done", done, 1);
        chk("s6_busy", busy, 0);
        chk("s6_run", run_en, 0);
        chk("s6_hits", hits, 5);
        chk("s6_pidx2", period_idx, 2);
        tick(2);
        reset = 1'b0;
        #1;
        chk("s6_arst_done", done, 0);
        chk("s6_arst_hits", hits, 0);
        chk("s6_arst_pidx", period_idx, 0);
        chk("s6_arst_run", run_en, 0);
        chk("s6_arst_busy", busy, 0);
        chk("s6_arst_clr", clr, 0);
        tick(1);
        reset = 1'b1;
        tick(4);
        chk("s6_post_busy", busy, 0);
        chk("s6_post_done", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
